// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// the 3-sample majority helper used for mid-bit voting.
package uart_pkg;

    // Bit period in clk cycles; shared with the uart2 transmitter.
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Majority of three samples, so a single corrupted sample cannot flip a bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad, plus a falling-edge
// detect on the synchronized line used to spot a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_pin,
    output logic rx_s,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the pad value through the chain and keep one older copy for edge detection.
    always_comb begin
        meta_d = rx_pin;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Preset to the idle-high level so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s = sync_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with mid-bit majority voting, glitch-rejecting start
// check, framing check, break handling and a valid/ready byte output with
// overrun reporting.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic rx_s;
    logic fall;

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   samp0_q, samp0_d;
    logic                   samp1_q, samp1_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic                   wrap;
    logic                   at_vote;
    logic                   vote;
    logic                   deliver;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx_pin (rx_pin),
        .rx_s   (rx_s),
        .fall   (fall)
    );

    assign wrap    = (cnt_q == CNT_LAST);
    assign at_vote = (cnt_q == CNT_VOTE);
    assign vote    = maj3(samp0_q, samp1_q, rx_s);

    // Frame sequencing, bit timing, sampling and the output handshake register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        sh_d        = sh_q;
        samp0_d     = (cnt_q == CNT_S0) ? rx_s : samp0_q;
        samp1_d     = (cnt_q == CNT_S1) ? rx_s : samp1_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (at_vote && vote) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_vote) begin
                    sh_d[idx_q] = vote;
                end
                if (wrap) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (at_vote) begin
                    if (vote) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = sh_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Register all state; reset drops any partial or pending byte without flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            samp0_q     <= 1'b1;
            samp1_q     <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            samp0_q     <= samp0_d;
            samp1_q     <= samp1_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed serial frames are driven on
// rx_pin, expected bytes are queued, and a monitor pops and compares on
// every rx_valid & rx_ready handshake.
module tb_uart_rx_os;

    localparam int C       = 16;
    localparam int H       = C / 2;
    localparam int LATENCY = 9 * C + H + 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_pin = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];

    int cycleCount    = 0;
    int startCycle    = 0;
    int riseCycle     = 0;
    int validCycles   = 0;
    int frameErrCount = 0;
    int overrunCount  = 0;
    int busyCycles    = 0;
    logic prevValid   = 1'b0;

    int v0, f0, o0, b0;

    uart_rx_os #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_pin    (rx_pin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Free-running clock and a cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one frame LSB first; glitchMask pulls chosen data bits low for one
    // mid-bit cycle; abortBit >= 0 stops mid data bit abortBit with the line as is.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic [7:0] glitchMask, input int abortBit);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < C; j++) begin
                @(negedge clk);
                if (b == 0 && j == 0) startCycle = cycleCount;
                if (b >= 1 && b <= 8 && glitchMask[b-1] && j == H + 1)
                    rx_pin = 1'b0;
                else
                    rx_pin = frame[b];
                if (abortBit >= 0 && b == abortBit + 1 && j == H) return;
            end
        end
    endtask

    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) checkOutput("drain timeout", expQ.size(), 0);
    endtask

    // Monitor: samples mid-cycle, counts flag pulses and compares delivered bytes.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (rx_valid) validCycles++;
                if (rx_valid && !prevValid) riseCycle = cycleCount;
                if (frame_err) frameErrCount++;
                if (overrun) overrunCount++;
                if (rx_busy) busyCycles++;
                if (rx_valid && rx_ready) begin
                    if (expQ.size() == 0)
                        checkOutput("unexpected byte", int'(rx_data), -1);
                    else
                        checkOutput("rx_data", int'(rx_data), int'(expQ.pop_front()));
                end
            end
            prevValid = rx_valid;
        end
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset rx_valid", int'(rx_valid), 0);
        checkOutput("reset rx_data", int'(rx_data), 0);
        checkOutput("reset rx_busy", int'(rx_busy), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // T1: clean 0x41 with ready held high.
        v0 = validCycles; f0 = frameErrCount; o0 = overrunCount;
        rx_ready = 1'b1;
        expQ.push_back(8'h41);
        applyStimulus(8'h41, 1'b1, 8'h00, -1);
        waitDrain(4 * C);
        repeat (C) @(negedge clk);
        checkOutput("T1 valid cycles", validCycles - v0, 1);
        checkOutput("T1 latency", riseCycle - startCycle - 1, LATENCY);
        checkOutput("T1 frame_err", frameErrCount - f0, 0);
        checkOutput("T1 overrun", overrunCount - o0, 0);

        // T2: two back-to-back frames while the consumer stalls.
        o0 = overrunCount;
        rx_ready = 1'b0;
        expQ.push_back(8'h55);
        applyStimulus(8'h55, 1'b1, 8'h00, -1);
        applyStimulus(8'hAA, 1'b1, 8'h00, -1);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("T2 overrun pulses", overrunCount - o0, 1);
        checkOutput("T2 held valid", int'(rx_valid), 1);
        checkOutput("T2 held data", int'(rx_data), 8'h55);
        @(negedge clk);
        rx_ready = 1'b1;
        waitDrain(4 * C);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("T2 valid after accept", int'(rx_valid), 0);

        // T3: short low pulse rejected at the start vote.
        v0 = validCycles; f0 = frameErrCount; b0 = busyCycles;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_pin = 1'b0;
        end
        @(negedge clk);
        rx_pin = 1'b1;
        repeat (2 * C) @(negedge clk);
        #1;
        checkOutput("T3 busy cycles", busyCycles - b0, H + 2);
        checkOutput("T3 valid", validCycles - v0, 0);
        checkOutput("T3 frame_err", frameErrCount - f0, 0);
        checkOutput("T3 busy idle", int'(rx_busy), 0);

        // T4: bad stop bit followed by a long break.
        v0 = validCycles; f0 = frameErrCount; o0 = overrunCount;
        applyStimulus(8'h41, 1'b0, 8'h00, -1);
        repeat (20 * C) @(negedge clk);
        #1;
        checkOutput("T4 busy during break", int'(rx_busy), 1);
        @(negedge clk);
        rx_pin = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("T4 busy after break", int'(rx_busy), 0);
        checkOutput("T4 frame_err pulses", frameErrCount - f0, 1);
        checkOutput("T4 valid", validCycles - v0, 0);
        checkOutput("T4 overrun", overrunCount - o0, 0);

        // T5: one-cycle low glitches on a vote sample of data bits 0 and 3.
        v0 = validCycles; f0 = frameErrCount;
        expQ.push_back(8'h41);
        applyStimulus(8'h41, 1'b1, 8'b0000_1001, -1);
        waitDrain(4 * C);
        repeat (C) @(negedge clk);
        checkOutput("T5 valid cycles", validCycles - v0, 1);
        checkOutput("T5 frame_err", frameErrCount - f0, 0);

        // T6: reset mid data bit 4 while a byte is still pending.
        f0 = frameErrCount;
        rx_ready = 1'b0;
        applyStimulus(8'h41, 1'b1, 8'h00, -1);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("T6 pending valid", int'(rx_valid), 1);
        checkOutput("T6 pending data", int'(rx_data), 8'h41);
        applyStimulus(8'h41, 1'b1, 8'h00, 4);
        checkOutput("T6 busy before reset", int'(rx_busy), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("T6 reset rx_valid", int'(rx_valid), 0);
        checkOutput("T6 reset rx_data", int'(rx_data), 0);
        checkOutput("T6 reset rx_busy", int'(rx_busy), 0);
        checkOutput("T6 reset frame_err", int'(frame_err), 0);
        checkOutput("T6 reset overrun", int'(overrun), 0);
        @(negedge clk);
        rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (C) @(negedge clk);
        #1;
        checkOutput("T6 idle after reset", int'(rx_busy), 0);
        rx_ready = 1'b1;
        expQ.push_back(8'h41);
        applyStimulus(8'h41, 1'b1, 8'h00, -1);
        waitDrain(4 * C);
        repeat (C) @(negedge clk);
        checkOutput("T6 frame_err", frameErrCount - f0, 0);

        repeat (10) @(negedge clk);
        checkOutput("scoreboard empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
